fix_complex_div: RTL and testbench



---
 rtl/fix_complex_div_pkg.sv | 20 ++
 rtl/fix_complex_div_if.sv | 25 ++
 rtl/fix_complex_div_udiv.sv | 55 +++++
 rtl/fix_complex_div.sv | 156 +++++++++++++++
 tb/tb_fix_complex_div.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/fix_complex_div_pkg.sv
// Shared definitions for the fixed-point complex divider: default word
// geometry, FSM state encoding and the iteration-count helper.
package fix_complex_div_pkg;

  localparam int WS_DEFAULT = 16;
  localparam int DP_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PREP = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // One quotient bit per iteration; the shifted magnitude plus a sign-guard bit.
  function automatic int div_iters(input int ws, input int dp);
    return 2 * ws + dp + 1;
  endfunction

endpackage

// File: rtl/fix_complex_div_if.sv
// Request/response bundle of the complex divider; operands and result are
// packed {im, re} two's complement words of ws bits each.
interface fix_complex_div_if #(
  parameter int ws = fix_complex_div_pkg::WS_DEFAULT
) ();

  logic            start;
  logic [2*ws-1:0] a;
  logic [2*ws-1:0] b;
  logic [2*ws-1:0] c;
  logic            busy;
  logic            done;
  logic            div_by_zero;

  modport master (
    output start, a, b,
    input  c, busy, done, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output c, busy, done, div_by_zero
  );

endinterface

// File: rtl/fix_complex_div_udiv.sv
// Unsigned restoring divider, one quotient bit per load/step; load performs
// the first iteration directly on the incoming dividend.
module fix_udiv_seq #(
  parameter int DW = 41,
  parameter int VW = 33
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [VW-1:0] divisor_i,
  output logic [DW-1:0] quotient_o
);

  logic [DW-1:0] dvd_q, dvd_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [VW-1:0] rem_q, rem_d;
  logic [VW-1:0] dsr_q, dsr_d;
  logic [DW-1:0] src_dvd;
  logic [VW-1:0] src_rem;
  logic [VW:0]   rem_sh;
  logic [VW-1:0] diff;
  logic          ge;

  // A set top bit of the shifted remainder already exceeds any divisor.
  always_comb begin
    src_dvd = load_i ? dividend_i : dvd_q;
    src_rem = load_i ? '0 : rem_q;
    dsr_d   = load_i ? divisor_i : dsr_q;
    rem_sh  = {src_rem, src_dvd[DW-1]};
    ge      = rem_sh[VW] | (rem_sh[VW-1:0] >= dsr_d);
    diff    = rem_sh[VW-1:0] - dsr_d;
    rem_d   = ge ? diff : rem_sh[VW-1:0];
    dvd_d   = {src_dvd[DW-2:0], 1'b0};
    quo_d   = load_i ? {{(DW-1){1'b0}}, ge} : {quo_q[DW-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else if (load_i || step_i) begin
      dvd_q <= dvd_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient_o = quo_q;

endmodule

// File: rtl/fix_complex_div.sv
// Sequential fixed-point complex divider c = a*conj(b)/|b|^2, truncating
// toward zero and saturating each component to the ws-bit range.
module fix_complex_div
  import fix_complex_div_pkg::*;
#(
  parameter int ws = WS_DEFAULT,
  parameter int dp = DP_DEFAULT
) (
  input logic              clk,
  input logic              rst,
  fix_complex_div_if.slave bus_if
);

  localparam int NB = div_iters(ws, dp);
  localparam int NW = 2 * ws + 1;
  localparam int CW = $clog2(NB);
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);
  localparam logic [NB-1:0] MAX_POS  = {{(NB-ws+1){1'b0}}, {(ws-1){1'b1}}};
  localparam logic [NB-1:0] MIN_MAG  = {{(NB-ws){1'b0}}, 1'b1, {(ws-1){1'b0}}};

  state_e          state_q, state_d;
  logic [2*ws-1:0] a_q, b_q;
  logic [2*ws-1:0] c_q;
  logic            dbz_q;
  logic            neg_re_q, neg_im_q;
  logic [CW-1:0]   cnt_q;

  logic signed [NW-1:0] ar, ai, br, bi;
  logic signed [NW-1:0] num_re, num_im, den;
  logic [NW-1:0]        mag_re, mag_im;
  logic [NB-1:0]        quo_re, quo_im;
  logic                 den_zero;
  logic                 accept, div_load, div_step;

  function automatic logic [ws-1:0] saturate(input logic [NB-1:0] q, input logic neg);
    if (neg) begin
      if (q > MIN_MAG) return {1'b1, {(ws-1){1'b0}}};
      return (~q[ws-1:0]) + {{(ws-1){1'b0}}, 1'b1};
    end
    if (q > MAX_POS) return {1'b0, {(ws-1){1'b1}}};
    return q[ws-1:0];
  endfunction

  // Full-precision products; NW bits hold every sum and difference exactly.
  assign ar       = {{(ws+1){a_q[ws-1]}},   a_q[ws-1:0]};
  assign ai       = {{(ws+1){a_q[2*ws-1]}}, a_q[2*ws-1:ws]};
  assign br       = {{(ws+1){b_q[ws-1]}},   b_q[ws-1:0]};
  assign bi       = {{(ws+1){b_q[2*ws-1]}}, b_q[2*ws-1:ws]};
  assign num_re   = ar * br + ai * bi;
  assign num_im   = ai * br - ar * bi;
  assign den      = br * br + bi * bi;
  assign den_zero = (den == '0);
  assign mag_re   = num_re[NW-1] ? -num_re : num_re;
  assign mag_im   = num_im[NW-1] ? -num_im : num_im;

  fix_udiv_seq #(.DW(NB), .VW(NW)) u_div_re (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i ({mag_re, {dp{1'b0}}}),
    .divisor_i  (den),
    .quotient_o (quo_re)
  );

  fix_udiv_seq #(.DW(NB), .VW(NW)) u_div_im (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i ({mag_im, {dp{1'b0}}}),
    .divisor_i  (den),
    .quotient_o (quo_im)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus_if.start) state_d = ST_PREP;
      ST_PREP: state_d = den_zero ? ST_DONE : ST_DIV;
      ST_DIV:  if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: state_d = bus_if.start ? ST_PREP : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The load edge is the first division iteration, so DIV only needs NB-1 steps.
  always_comb begin
    bus_if.busy = 1'b0;
    bus_if.done = 1'b0;
    accept      = 1'b0;
    div_load    = 1'b0;
    div_step    = 1'b0;
    case (state_q)
      ST_IDLE: accept = bus_if.start;
      ST_PREP: begin
        bus_if.busy = 1'b1;
        div_load    = !den_zero;
      end
      ST_DIV: begin
        bus_if.busy = 1'b1;
        div_step    = (cnt_q != CNT_LAST);
      end
      ST_DONE: begin
        bus_if.done = 1'b1;
        accept      = bus_if.start;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      dbz_q    <= 1'b0;
      neg_re_q <= 1'b0;
      neg_im_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        a_q <= bus_if.a;
        b_q <= bus_if.b;
      end
      case (state_q)
        ST_PREP: begin
          cnt_q    <= '0;
          neg_re_q <= num_re[NW-1];
          neg_im_q <= num_im[NW-1];
          if (den_zero) begin
            c_q   <= '0;
            dbz_q <= 1'b1;
          end
        end
        ST_DIV: begin
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            c_q   <= {saturate(quo_im, neg_im_q), saturate(quo_re, neg_re_q)};
            dbz_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus_if.c           = c_q;
  assign bus_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_fix_complex_div.sv
// Self-checking bench for fix_complex_div: directed cases plus random
// operands checked against an integer-arithmetic reference model.
module tb_fix_complex_div;

  localparam int WS = 16;
  localparam int DP = 8;
  localparam int LAT_DIV = 2 * WS + DP + 3;
  localparam int LAT_DBZ = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fix_complex_div_if #(.ws(WS)) bus ();

  fix_complex_div #(.ws(WS), .dp(DP)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  function automatic logic [15:0] ref_comp(input longint n, input longint den);
    longint m;
    longint q;
    m = (n < 0) ? -n : n;
    q = (m * (64'sd1 <<< DP)) / den;
    if (n < 0) q = -q;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] c, output logic dbz);
    longint ar, ai, br, bi, den;
    ar  = longint'($signed(a[15:0]));
    ai  = longint'($signed(a[31:16]));
    br  = longint'($signed(b[15:0]));
    bi  = longint'($signed(b[31:16]));
    den = br * br + bi * bi;
    if (den == 0) begin
      c   = 32'h0;
      dbz = 1'b1;
    end else begin
      c   = {ref_comp(ai * br - ar * bi, den), ref_comp(ar * br + ai * bi, den)};
      dbz = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents operands for one clock; returns at the negedge of cycle 1.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cyc);
    cyc = from;
    while (bus.done !== 1'b1 && cyc < 150) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) cyc = -1;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp_c;
    logic        exp_z;
    int          cyc;
    ref_div(a, b, exp_c, exp_z);
    applyStimulus(a, b);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(1));
    wait_done(1, cyc);
    checkOutput({tag, "_lat"}, 64'(cyc), 64'(exp_z ? LAT_DBZ : LAT_DIV));
    checkOutput({tag, "_c"}, 64'(bus.c), 64'(exp_c));
    checkOutput({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(exp_z));
  endtask

  initial begin
    logic [31:0] ra, rb, exp_c;
    logic [15:0] t0, t1;
    logic        exp_z;
    int          cyc;
    int          extra;

    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 64'(bus.busy), 64'(0));
    checkOutput("rst_done", 64'(bus.done), 64'(0));
    checkOutput("rst_c", 64'(bus.c), 64'(0));
    checkOutput("rst_dbz", 64'(bus.div_by_zero), 64'(0));
    rst = 1'b0;

    run_op("one_over_j", 32'h0000_0100, 32'h0100_0000);
    checkOutput("one_over_j_exact", 64'(bus.c), 64'h0000_0000_FF00_0000);
    run_op("three4j", 32'h0400_0300, 32'h0200_0100);
    checkOutput("three4j_exact", 64'(bus.c), 64'h0000_0000_FF9A_0233);
    run_op("bzero", 32'h1234_5678, 32'h0000_0000);
    run_op("after_bzero", 32'h0000_0200, 32'h0000_0100);
    checkOutput("after_bzero_exact", 64'(bus.c), 64'h0000_0000_0000_0200);
    run_op("sat_pos", 32'h0000_7F00, 32'h0000_0001);
    checkOutput("sat_pos_exact", 64'(bus.c), 64'h0000_0000_0000_7FFF);
    run_op("sat_neg", 32'h0000_8100, 32'h0000_0001);
    checkOutput("sat_neg_exact", 64'(bus.c), 64'h0000_0000_0000_8000);

    // A start pulse mid-operation must be dropped entirely.
    ref_div(32'h0400_0300, 32'h0200_0100, exp_c, exp_z);
    applyStimulus(32'h0400_0300, 32'h0200_0100);
    repeat (9) @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h7FFF_7FFF;
    bus.b     = 32'h0000_0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(11, cyc);
    checkOutput("ignore_lat", 64'(cyc), 64'(LAT_DIV));
    checkOutput("ignore_c", 64'(bus.c), 64'(exp_c));
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    checkOutput("ignore_no_extra_done", 64'(extra), 64'(0));

    // Back-to-back: start held high during the DONE cycle.
    applyStimulus(32'h0000_0100, 32'h0100_0000);
    wait_done(1, cyc);
    checkOutput("b2b_first_c", 64'(bus.c), 64'h0000_0000_FF00_0000);
    checkOutput("b2b_first_busy", 64'(bus.busy), 64'(0));
    ref_div(32'h0400_0300, 32'h0200_0100, exp_c, exp_z);
    bus.start = 1'b1;
    bus.a     = 32'h0400_0300;
    bus.b     = 32'h0200_0100;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(1, cyc);
    checkOutput("b2b_second_lat", 64'(cyc), 64'(LAT_DIV));
    checkOutput("b2b_second_c", 64'(bus.c), 64'(exp_c));

    // Reset during DIV aborts the operation.
    applyStimulus(32'h0300_0500, 32'h0100_0100);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", 64'(bus.busy), 64'(0));
    checkOutput("abort_c", 64'(bus.c), 64'(0));
    checkOutput("abort_dbz", 64'(bus.div_by_zero), 64'(0));
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done === 1'b1) extra++;
    end
    checkOutput("abort_no_done", 64'(extra), 64'(0));
    run_op("after_abort", 32'h0300_0500, 32'h0100_0100);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1, 2, 3: begin
          t0 = 16'($urandom_range(0, 16)) - 16'd8;
          t1 = 16'($urandom_range(0, 16)) - 16'd8;
          rb = {t1, t0};
        end
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ra, rb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
